// File: rtl/vending_machine.sv
// vending_machine: coin-operated vending controller for four items.
// Accepts nickel/dime pulses, accumulates credit in 5-cent units, dispenses
// the latched item once credit covers its price, and returns change nickels.
// Optional feature macro: VEND_COUNTER_EN adds an 8-bit vend_count output.
module vending_machine #(
  parameter int PRICE_0     = 3,
  parameter int PRICE_1     = 4,
  parameter int PRICE_2     = 5,
  parameter int PRICE_3     = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] item_number,
  input  logic       nickel_in,
  input  logic       dime_in,
  output logic       nickel_out,
  output logic       dispense
`ifdef VEND_COUNTER_EN
  ,
  output logic [7:0] vend_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_VEND  = 2'd2
  } state_t;

  // Last hold-counter value for a single vend and for a double-nickel vend.
  localparam logic [4:0] HOLD_LAST   = 5'(HOLD_CYCLES - 1);
  localparam logic [4:0] HOLD2_LAST  = 5'(2 * HOLD_CYCLES - 1);

  state_t     r_state,      w_state_next;
  logic [3:0] r_credit,     w_credit_next;
  logic [1:0] r_item,       w_item_next;
  logic [4:0] r_hold_cnt,   w_hold_cnt_next;
  logic       r_double,     w_double_next;   // two change nickels owed
  logic       r_dispense,   w_dispense_next;
  logic       r_nickel_out, w_nickel_out_next;

  logic [1:0] w_coin_units;
  logic [3:0] w_price;
  logic [3:0] w_overshoot;
  logic [4:0] w_hold_last;
  logic       w_vend_entry;

  function automatic logic [3:0] price_of(input logic [1:0] item);
    case (item)
      2'b00:   price_of = 4'(PRICE_0);
      2'b01:   price_of = 4'(PRICE_1);
      2'b10:   price_of = 4'(PRICE_2);
      default: price_of = 4'(PRICE_3);
    endcase
  endfunction

  // Coin value this edge (nickel+dime together is 3 units) and current price.
  assign w_coin_units = {1'b0, nickel_in} + {dime_in, 1'b0};
  assign w_price      = price_of(r_item);
  assign w_overshoot  = r_credit - w_price;
  assign w_hold_last  = r_double ? HOLD2_LAST : HOLD_LAST;
  assign w_vend_entry = (r_state == S_ACCUM) && (w_state_next == S_VEND);

  // Next-state and next-output logic for the vend controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_state_next      = r_state;
    w_credit_next     = r_credit;
    w_item_next       = r_item;
    w_hold_cnt_next   = r_hold_cnt;
    w_double_next     = r_double;
    w_dispense_next   = r_dispense;
    w_nickel_out_next = r_nickel_out;

    case (r_state)
      S_IDLE: begin
        if (w_coin_units != 2'd0) begin
          w_item_next   = item_number;
          w_credit_next = {2'b00, w_coin_units};
          w_state_next  = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (r_credit >= w_price) begin
          // Committed to vend: coins on this edge are not credited.
          w_state_next      = S_VEND;
          w_hold_cnt_next   = 5'd0;
          w_dispense_next   = 1'b1;
          w_nickel_out_next = (w_overshoot != 4'd0);
          w_double_next     = (w_overshoot == 4'd2);
        end else begin
          w_credit_next = r_credit + {2'b00, w_coin_units};
        end
      end

      S_VEND: begin
        if (r_hold_cnt == w_hold_last) begin
          w_state_next      = S_IDLE;
          w_credit_next     = 4'd0;
          w_hold_cnt_next   = 5'd0;
          w_double_next     = 1'b0;
          w_dispense_next   = 1'b0;
          w_nickel_out_next = 1'b0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 5'd1;
          // Second change nickel: dispense ends, nickel_out keeps going.
          if (r_hold_cnt == HOLD_LAST) begin
            w_dispense_next = 1'b0;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      r_state      <= S_IDLE;
      r_credit     <= 4'd0;
      r_item       <= 2'd0;
      r_hold_cnt   <= 5'd0;
      r_double     <= 1'b0;
      r_dispense   <= 1'b0;
      r_nickel_out <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_credit     <= w_credit_next;
      r_item       <= w_item_next;
      r_hold_cnt   <= w_hold_cnt_next;
      r_double     <= w_double_next;
      r_dispense   <= w_dispense_next;
      r_nickel_out <= w_nickel_out_next;
    end
  end

  assign dispense   = r_dispense;
  assign nickel_out = r_nickel_out;

`ifdef VEND_COUNTER_EN
  logic [7:0] r_vend_count;

  // Count entries into VEND, wrapping at 255.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vend_count <= 8'd0;
    end else if (w_vend_entry) begin
      r_vend_count <= r_vend_count + 8'd1;
    end
  end

  assign vend_count = r_vend_count;
`else
  logic w_unused_vend_entry;
  assign w_unused_vend_entry = w_vend_entry;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed and randomized stimulus for vending_machine,
// checked every cycle against a transaction-level model of the vending rules.
module tb_vending_machine;

  localparam int HOLD = 4;

  logic       clock;
  logic       reset;
  logic [1:0] item_number;
  logic       nickel_in;
  logic       dime_in;
  logic       nickel_out;
  logic       dispense;
`ifdef VEND_COUNTER_EN
  logic [7:0] vend_count;
`endif

  vending_machine #(
    .PRICE_0(3), .PRICE_1(4), .PRICE_2(5), .PRICE_3(6), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .item_number(item_number),
    .nickel_in  (nickel_in),
    .dime_in    (dime_in),
    .nickel_out (nickel_out),
    .dispense   (dispense)
`ifdef VEND_COUNTER_EN
    ,
    .vend_count (vend_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: credit in units, latched item, and remaining cycles of
  // each output pulse once a vend has been committed.
  int         price_tab[4] = '{3, 4, 5, 6};
  int         m_credit;
  int         m_item;
  int         m_disp_left;
  int         m_nick_left;
  int         m_busy;
  logic [7:0] m_vends;

  task automatic model_edge(input logic rst, input logic [1:0] item,
                            input logic n, input logic d);
    int units;
    int over;
    units = int'(n) + 2 * int'(d);
    if (rst) begin
      m_credit = 0; m_item = 0; m_disp_left = 0; m_nick_left = 0;
      m_busy = 0; m_vends = 8'd0;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
      if (m_disp_left > 0) m_disp_left = m_disp_left - 1;
      if (m_nick_left > 0) m_nick_left = m_nick_left - 1;
    end else if (m_credit > 0 && m_credit >= price_tab[m_item]) begin
      over        = m_credit - price_tab[m_item];
      m_disp_left = HOLD;
      m_nick_left = over * HOLD;
      m_busy      = (over == 2) ? 2 * HOLD : HOLD;
      m_credit    = 0;
      m_vends     = m_vends + 8'd1;
    end else begin
      if (m_credit == 0 && units > 0) m_item = int'(item);
      m_credit = m_credit + units;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic step(input string tag, input logic rst, input logic [1:0] item,
                      input logic n, input logic d);
    reset = rst; item_number = item; nickel_in = n; dime_in = d;
    @(posedge clock);
    model_edge(rst, item, n, d);
    #1;
    check({tag, ".dispense"}, dispense, (m_disp_left > 0));
    check({tag, ".nickel_out"}, nickel_out, (m_nick_left > 0));
`ifdef VEND_COUNTER_EN
    total++;
    assert (vend_count === m_vends) else begin
      bad++;
      $error("FAIL %s.vend_count observed=%0d expected=%0d", tag, vend_count, m_vends);
    end
`endif
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; item_number = 2'b00; nickel_in = 1'b0; dime_in = 1'b0;
    m_credit = 0; m_item = 0; m_disp_left = 0; m_nick_left = 0;
    m_busy = 0; m_vends = 8'd0;

    step("reset", 1'b1, 2'b00, 1'b0, 1'b0);
    step("reset", 1'b1, 2'b00, 1'b1, 1'b1);

    // Item 00, three separate nickels: exact payment.
    step("i0_n1", 1'b0, 2'b00, 1'b1, 1'b0);
    step("i0_gap", 1'b0, 2'b00, 1'b0, 1'b0);
    step("i0_n2", 1'b0, 2'b00, 1'b1, 1'b0);
    step("i0_n3", 1'b0, 2'b00, 1'b1, 1'b0);
    idle("i0_nnn_vend", 7);

    // Item 00, two dimes: one nickel change.
    step("i0_d1", 1'b0, 2'b00, 1'b0, 1'b1);
    step("i0_d2", 1'b0, 2'b00, 1'b0, 1'b1);
    idle("i0_dd_vend", 7);

    // Item 01, two dimes exact; then three nickels and a dime with change.
    step("i1_d1", 1'b0, 2'b01, 1'b0, 1'b1);
    step("i1_d2", 1'b0, 2'b01, 1'b0, 1'b1);
    idle("i1_dd_vend", 6);
    step("i1_n1", 1'b0, 2'b01, 1'b1, 1'b0);
    step("i1_n2", 1'b0, 2'b01, 1'b1, 1'b0);
    step("i1_n3", 1'b0, 2'b01, 1'b1, 1'b0);
    step("i1_d", 1'b0, 2'b01, 1'b0, 1'b1);
    idle("i1_nnnd_vend", 6);

    // Item 10, three nickels and a dime exact; then three dimes with change.
    step("i2_n1", 1'b0, 2'b10, 1'b1, 1'b0);
    step("i2_n2", 1'b0, 2'b10, 1'b1, 1'b0);
    step("i2_n3", 1'b0, 2'b10, 1'b1, 1'b0);
    step("i2_d", 1'b0, 2'b10, 1'b0, 1'b1);
    idle("i2_nnnd_vend", 6);
    step("i2_d1", 1'b0, 2'b10, 1'b0, 1'b1);
    step("i2_d2", 1'b0, 2'b10, 1'b0, 1'b1);
    step("i2_d3", 1'b0, 2'b10, 1'b0, 1'b1);
    idle("i2_ddd_vend", 6);

    // Item 00, nickel and dime on the same edge: vend next edge, no change.
    step("i0_nd", 1'b0, 2'b00, 1'b1, 1'b1);
    idle("i0_nd_vend", 6);

    // Reset after one dime discards credit; a later nickel must not vend.
    step("rst_d", 1'b0, 2'b00, 1'b0, 1'b1);
    step("rst_mid", 1'b1, 2'b00, 1'b0, 1'b0);
    step("rst_n", 1'b0, 2'b00, 1'b1, 1'b0);
    idle("rst_after", 4);
    step("rst_clear", 1'b1, 2'b00, 1'b0, 1'b0);

    // Coins during VEND are ignored.
    step("vc_d1", 1'b0, 2'b00, 1'b0, 1'b1);
    step("vc_n", 1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("vc_coins", 1'b0, 2'b00, 1'b0, 1'b1);
    idle("vc_after", 4);

    // item_number changed mid-ACCUM: price of item 10 still governs.
    step("ich_n1", 1'b0, 2'b10, 1'b1, 1'b0);
    step("ich_n2", 1'b0, 2'b00, 1'b1, 1'b0);
    step("ich_n3", 1'b0, 2'b00, 1'b1, 1'b0);
    idle("ich_wait", 2);
    step("ich_d", 1'b0, 2'b00, 1'b0, 1'b1);
    idle("ich_vend", 6);

    // Two units of overshoot: nickel_out lasts two hold periods.
    step("dbl_n1", 1'b0, 2'b01, 1'b1, 1'b0);
    step("dbl_n2", 1'b0, 2'b01, 1'b1, 1'b0);
    step("dbl_n3", 1'b0, 2'b01, 1'b1, 1'b0);
    step("dbl_nd", 1'b0, 2'b01, 1'b1, 1'b1);
    idle("dbl_vend", 11);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] r_it;
      logic r_n, r_d, r_rst;
      r_it  = 2'($urandom_range(0, 3));
      r_n   = ($urandom_range(0, 3) == 0);
      r_d   = ($urandom_range(0, 4) == 0);
      r_rst = ($urandom_range(0, 63) == 0);
      step("rand", r_rst, r_it, r_n, r_d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
